// File: rtl/nios2_ocimem_arbiter.sv
// Arbitrates the Nios II on-chip debug RAM between the JTAG debug host and the
// CPU Avalon debug slave, sequencing single-port accesses with 1-cycle read latency.
module nios2_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jreq_valid,
  input  logic              jreq_write,
  input  logic [ADDR_W-1:0] jreq_addr,
  input  logic [DATA_W-1:0] jreq_wdata,
  input  logic              debugack,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jresp_valid,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;
  typedef enum logic {OWN_CPU, OWN_JTAG} owner_t;

  state_t state, state_nxt;
  owner_t owner, last_owner;

  logic              jpend;
  logic              jpend_write;
  logic [ADDR_W-1:0] jpend_addr;
  logic [DATA_W-1:0] jpend_wdata;

  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;

  logic cpu_req;
  logic grant_jtag;
  logic grant_cpu;
  logic jreq_accept;

  assign cpu_req     = avs_read | avs_write;
  // A pulse is taken if the slot is free or is being vacated by this cycle's grant.
  assign jreq_accept = jreq_valid & (~jpend | grant_jtag);

  always_comb begin
    grant_jtag = 1'b0;
    grant_cpu  = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE: begin
        if (jpend && (!cpu_req || debugack || last_owner == OWN_CPU)) grant_jtag = 1'b1;
        else if (cpu_req) grant_cpu = 1'b1;
        if (grant_jtag || grant_cpu) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = op_we ? RESPOND : CAPTURE;
      CAPTURE: state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jpend       <= 1'b0;
      jpend_write <= 1'b0;
      jpend_addr  <= '0;
      jpend_wdata <= '0;
    end else if (jreq_accept) begin
      jpend       <= 1'b1;
      jpend_write <= jreq_write;
      jpend_addr  <= jreq_addr;
      jpend_wdata <= jreq_wdata;
    end else if (grant_jtag) begin
      jpend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else if (jreq_accept) begin
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (jreq_valid) monitor_error <= 1'b1;
      if (state == RESPOND && owner == OWN_JTAG) monitor_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner        <= OWN_CPU;
      last_owner   <= OWN_CPU;
      op_we        <= 1'b0;
      op_addr      <= '0;
      op_wdata     <= '0;
      avs_readdata <= '0;
      MonDReg      <= '0;
    end else begin
      if (grant_jtag) begin
        owner    <= OWN_JTAG;
        op_we    <= jpend_write;
        op_addr  <= jpend_addr;
        op_wdata <= jpend_wdata;
      end else if (grant_cpu) begin
        owner    <= OWN_CPU;
        op_we    <= avs_write;
        op_addr  <= avs_address;
        op_wdata <= avs_writedata;
      end
      if (state == CAPTURE) begin
        if (owner == OWN_JTAG) MonDReg      <= ram_rdata;
        else                   avs_readdata <= ram_rdata;
      end
      if (state == RESPOND) last_owner <= owner;
    end
  end

  assign ram_en          = (state == ISSUE);
  assign ram_we          = (state == ISSUE) & op_we;
  assign ram_addr        = op_addr;
  assign ram_wdata       = op_wdata;
  assign jresp_valid     = (state == RESPOND) & (owner == OWN_JTAG);
  assign avs_waitrequest = ~((state == RESPOND) & (owner == OWN_CPU));

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Bench for nios2_ocimem_arbiter: directed scenarios plus random single
// transactions, checked against a word-level memory model and latency rules.
module tb_nios2_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        jreq_valid, jreq_write;
  logic [7:0]  jreq_addr;
  logic [31:0] jreq_wdata;
  logic        debugack;
  logic        avs_read, avs_write;
  logic [7:0]  avs_address;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        jresp_valid, monitor_ready, monitor_error;

  int n_chk  = 0;
  int n_fail = 0;
  int hits60 = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_mon;
  logic [7:0]  written[$];

  nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .jreq_valid(jreq_valid), .jreq_write(jreq_write),
    .jreq_addr(jreq_addr), .jreq_wdata(jreq_wdata),
    .debugack(debugack),
    .avs_read(avs_read), .avs_write(avs_write),
    .avs_address(avs_address), .avs_writedata(avs_writedata),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .jresp_valid(jresp_valid),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  always @(posedge clk) if (ram_en && ram_we && ram_addr == 8'h60) hits60++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic note_write(input logic [7:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    written.push_back(a);
  endtask

  // JTAG op issued into an idle arbiter: pulse at P, grant P+1, respond P+3/P+4.
  task automatic jtag_op(input bit wr, input logic [7:0] a, input logic [31:0] d);
    int lat;
    int en_at;
    logic en_we;
    logic [7:0] en_addr;
    logic [31:0] en_wd;
    en_at = -1; en_we = 1'b0; en_addr = '0; en_wd = '0;
    jreq_valid = 1'b1; jreq_write = wr; jreq_addr = a; jreq_wdata = d;
    step();
    jreq_valid = 1'b0;
    lat = 1;
    check("jtag_accept_ready_clr", {31'd0, monitor_ready}, 32'd0);
    check("jtag_accept_error_clr", {31'd0, monitor_error}, 32'd0);
    while (jresp_valid !== 1'b1 && lat < 20) begin
      if (ram_en === 1'b1) begin
        en_at = lat; en_we = ram_we; en_addr = ram_addr; en_wd = ram_wdata;
      end
      step();
      lat++;
    end
    check("jtag_latency", lat, wr ? 32'd3 : 32'd4);
    check("jtag_ram_en_cycle", en_at, 32'd2);
    check("jtag_ram_we", {31'd0, en_we}, {31'd0, wr});
    check("jtag_ram_addr", {24'd0, en_addr}, {24'd0, a});
    if (wr) begin
      check("jtag_ram_wdata", en_wd, d);
      note_write(a, d);
    end else begin
      ref_mon = ref_mem[a];
    end
    check("jtag_MonDReg", MonDReg, ref_mon);
    step();
    check("jresp_one_cycle", {31'd0, jresp_valid}, 32'd0);
    check("monitor_ready_set", {31'd0, monitor_ready}, 32'd1);
  endtask

  // CPU op into an idle arbiter: both strobes high means write.
  task automatic cpu_op(input bit wr, input bit rd, input logic [7:0] a, input logic [31:0] d);
    int lat;
    int en_at;
    logic en_we;
    logic [7:0] en_addr;
    bit exp_w;
    exp_w = wr;
    en_at = -1; en_we = 1'b0; en_addr = '0;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
    lat = 0;
    while (avs_waitrequest !== 1'b0 && lat < 20) begin
      if (ram_en === 1'b1) begin
        en_at = lat; en_we = ram_we; en_addr = ram_addr;
      end
      step();
      lat++;
    end
    check("cpu_latency", lat, exp_w ? 32'd2 : 32'd3);
    check("cpu_ram_en_cycle", en_at, 32'd1);
    check("cpu_ram_we", {31'd0, en_we}, {31'd0, exp_w});
    check("cpu_ram_addr", {24'd0, en_addr}, {24'd0, a});
    if (exp_w) note_write(a, d);
    else check("cpu_readdata", avs_readdata, ref_mem[a]);
    avs_read = 1'b0; avs_write = 1'b0;
    step();
    check("cpu_wait_high_after", {31'd0, avs_waitrequest}, 32'd1);
  endtask

  // JTAG read of 0x10 pulsed at P, CPU read of 0x20 raised at P+1: both contend at P+1.
  task automatic contend(input bit dbg, input bit jfirst);
    int lat;
    int jlat;
    int clat;
    debugack = dbg;
    jreq_valid = 1'b1; jreq_write = 1'b0; jreq_addr = 8'h10;
    step();
    jreq_valid = 1'b0;
    avs_read = 1'b1; avs_address = 8'h20;
    lat = 1; jlat = -1; clat = -1;
    while ((jlat < 0 || clat < 0) && lat < 30) begin
      if (jresp_valid === 1'b1) begin
        jlat = lat;
        check("contend_MonDReg", MonDReg, ref_mem[8'h10]);
      end
      if (avs_waitrequest === 1'b0) begin
        clat = lat;
        check("contend_readdata", avs_readdata, ref_mem[8'h20]);
        avs_read = 1'b0;
      end
      step();
      lat++;
    end
    check("contend_jtag_done", jlat, jfirst ? 32'd4 : 32'd8);
    check("contend_cpu_done", clat, jfirst ? 32'd8 : 32'd4);
    ref_mon = ref_mem[8'h10];
    debugack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    jreq_valid = 1'b0; jreq_write = 1'b0; jreq_addr = '0; jreq_wdata = '0;
    debugack = 1'b0;
    avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
    ref_mon = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_jresp", {31'd0, jresp_valid}, 32'd0);
    check("rst_ready", {31'd0, monitor_ready}, 32'd0);
    check("rst_error", {31'd0, monitor_error}, 32'd0);
    check("rst_MonDReg", MonDReg, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    reset_n = 1'b1;
    step();

    // JTAG write then read back
    jtag_op(1'b1, 8'h10, 32'hDEADBEEF);
    jtag_op(1'b0, 8'h10, 32'h0);
    check("jtag_readback", MonDReg, 32'hDEADBEEF);

    // CPU read of a word placed by the host
    jtag_op(1'b1, 8'h20, 32'h12345678);
    cpu_op(1'b0, 1'b1, 8'h20, 32'h0);
    check("cpu_readback", avs_readdata, 32'h12345678);

    // Contention: last owner CPU, no debugack -> JTAG first
    contend(1'b0, 1'b1);
    // last owner JTAG but debugack -> JTAG first
    jtag_op(1'b1, 8'h30, 32'hA5A5_0001);
    contend(1'b1, 1'b1);
    // last owner JTAG, no debugack -> CPU first
    jtag_op(1'b1, 8'h31, 32'hA5A5_0002);
    contend(1'b0, 1'b0);

    // Overrun: second pulse while first is pending and CPU holds the RAM
    avs_write = 1'b1; avs_address = 8'h40; avs_writedata = 32'h4040_4040;
    jreq_valid = 1'b1; jreq_write = 1'b1; jreq_addr = 8'h50; jreq_wdata = 32'h5050_5050;
    step();
    check("ovr_cpu_issue_addr", {24'd0, ram_addr}, 32'h40);
    jreq_addr = 8'h60; jreq_wdata = 32'h6060_6060;
    step();
    jreq_valid = 1'b0;
    check("ovr_error_set", {31'd0, monitor_error}, 32'd1);
    check("ovr_cpu_respond", {31'd0, avs_waitrequest}, 32'd0);
    avs_write = 1'b0;
    note_write(8'h40, 32'h4040_4040);
    step();
    step();
    check("ovr_first_en", {31'd0, ram_en}, 32'd1);
    check("ovr_first_addr", {24'd0, ram_addr}, 32'h50);
    check("ovr_first_wdata", ram_wdata, 32'h5050_5050);
    note_write(8'h50, 32'h5050_5050);
    step();
    check("ovr_first_resp", {31'd0, jresp_valid}, 32'd1);
    step();
    check("ovr_error_held", {31'd0, monitor_error}, 32'd1);
    check("ovr_ready_after", {31'd0, monitor_ready}, 32'd1);
    check("ovr_dropped_no_write", hits60, 32'd0);
    jtag_op(1'b0, 8'h50, 32'h0);
    cpu_op(1'b0, 1'b1, 8'h40, 32'h0);

    // Combined strobes act as a write
    cpu_op(1'b1, 1'b1, 8'h32, 32'hC0DE_F00D);
    jtag_op(1'b0, 8'h32, 32'h0);

    // Reset during CAPTURE of a CPU read
    avs_read = 1'b1; avs_address = 8'h20;
    step();
    step();
    reset_n = 1'b0;
    #1;
    avs_read = 1'b0;
    check("midrst_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
    check("midrst_ram_en", {31'd0, ram_en}, 32'd0);
    check("midrst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("midrst_readdata", avs_readdata, 32'd0);
    check("midrst_MonDReg", MonDReg, 32'd0);
    check("midrst_ready", {31'd0, monitor_ready}, 32'd0);
    ref_mon = '0;
    step();
    reset_n = 1'b1;
    step();
    cpu_op(1'b0, 1'b1, 8'h20, 32'h0);

    // Random single transactions
    for (int i = 0; i < 16; i++) begin
      int unsigned kind;
      logic [7:0] a;
      logic [31:0] d;
      kind = $urandom_range(0, 3);
      d = $urandom;
      if (kind[0] == 1'b0) a = 8'($urandom_range(0, 15));
      else a = written[$urandom_range(0, written.size() - 1)];
      if (kind[1]) jtag_op(~kind[0], a, d);
      else cpu_op(~kind[0], kind[0], a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
